// File: rtl/camera_downsampler.sv
// Capture front end between the OV7670 pixel bus and the frame buffer:
// frame alignment, byte pairing, format conversion, decimation and bounded writes.
module camera_downsampler #(
  parameter int WIDTH   = 176,
  parameter int HEIGHT  = 144,
  parameter int ADDR_W  = 15,
  parameter int X_DECIM = 1,
  parameter int Y_DECIM = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              DATA_VALID,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic              OVERFLOW,
  output logic              BUSY
);

  // Output counters carry one extra bit so they can sit past the frame bounds.
  localparam int CW = ADDR_W + 1;
  localparam int DW = 4;
  localparam logic [CW-1:0]     WIDTH_C  = CW'(WIDTH);
  localparam logic [CW-1:0]     HEIGHT_C = CW'(HEIGHT);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(WIDTH);
  localparam logic [DW-1:0]     XD_LAST  = DW'(X_DECIM - 1);
  localparam logic [DW-1:0]     YD_LAST  = DW'(Y_DECIM - 1);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    VBLANK  = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  function automatic logic [7:0] format_pixel(input logic [1:0] mode,
                                              input logic [7:0] b0,
                                              input logic [7:0] b1);
    logic [7:0] pix;
    case (mode)
      2'd0:    pix = {b0[7:5], b0[2:0], b1[4:3]};
      2'd1:    pix = b0;
      2'd2:    pix = b0;
      2'd3:    pix = {b1[4:3], b0[2:0], b0[7:5]};
      default: pix = b0;
    endcase
    return pix;
  endfunction

  state_t            state_r;
  logic              href_r;
  logic              phase_r;
  logic [7:0]        b0_r;
  logic [1:0]        mode_r;
  logic [DW-1:0]     xd_r;
  logic [DW-1:0]     yd_r;
  logic [CW-1:0]     x_out_r;
  logic [CW-1:0]     y_out_r;
  logic [ADDR_W-1:0] row_base_r;
  logic              line_kept_r;

  logic              byte_s;
  logic              href_fall_s;
  logic              keep_s;
  logic              in_bounds_s;
  logic [7:0]        pixel_s;

  // Byte qualification, line-end detection and keep/bounds decisions.
  always_comb begin
    byte_s      = HREF && DATA_VALID;
    href_fall_s = !HREF && href_r;
    keep_s      = (xd_r == DW'(0)) && (yd_r == DW'(0));
    in_bounds_s = (x_out_r < WIDTH_C) && (y_out_r < HEIGHT_C);
    pixel_s     = format_pixel(mode_r, b0_r, CAM_DATA);
  end

  // Frame state machine, capture datapath and registered write port.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r     <= WAIT_VS;
      href_r      <= 1'b0;
      phase_r     <= 1'b0;
      b0_r        <= 8'd0;
      mode_r      <= 2'd0;
      xd_r        <= DW'(0);
      yd_r        <= DW'(0);
      x_out_r     <= CW'(0);
      y_out_r     <= CW'(0);
      row_base_r  <= ADDR_W'(0);
      line_kept_r <= 1'b0;
      W_EN        <= 1'b0;
      W_ADDR      <= ADDR_W'(0);
      W_DATA      <= 8'd0;
      FRAME_DONE  <= 1'b0;
      OVERFLOW    <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      href_r     <= HREF;
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state_r)
        WAIT_VS: begin
          BUSY <= 1'b0;
          if (VSYNC) begin
            state_r <= VBLANK;
          end else begin
            state_r <= WAIT_VS;
          end
        end
        VBLANK: begin
          if (!VSYNC) begin
            state_r     <= ACTIVE;
            BUSY        <= 1'b1;
            mode_r      <= MODE;
            phase_r     <= 1'b0;
            xd_r        <= DW'(0);
            yd_r        <= DW'(0);
            x_out_r     <= CW'(0);
            y_out_r     <= CW'(0);
            row_base_r  <= ADDR_W'(0);
            line_kept_r <= 1'b0;
            OVERFLOW    <= 1'b0;
          end else begin
            state_r <= VBLANK;
            BUSY    <= 1'b0;
          end
        end
        ACTIVE: begin
          // Line end closes the row even when VSYNC rises in the same cycle.
          if (href_fall_s) begin
            phase_r     <= 1'b0;
            x_out_r     <= CW'(0);
            xd_r        <= DW'(0);
            line_kept_r <= 1'b0;
            yd_r        <= (yd_r == YD_LAST) ? DW'(0) : yd_r + DW'(1);
            if ((yd_r == DW'(0)) && line_kept_r) begin
              row_base_r <= row_base_r + STRIDE;
              if (y_out_r != {CW{1'b1}}) begin
                y_out_r <= y_out_r + CW'(1);
              end else begin
                y_out_r <= y_out_r;
              end
            end else begin
              row_base_r <= row_base_r;
            end
          end else if (byte_s) begin
            phase_r <= ~phase_r;
            if (!phase_r) begin
              b0_r <= CAM_DATA;
            end else begin
              xd_r <= (xd_r == XD_LAST) ? DW'(0) : xd_r + DW'(1);
              if (keep_s) begin
                line_kept_r <= 1'b1;
                if (x_out_r != {CW{1'b1}}) begin
                  x_out_r <= x_out_r + CW'(1);
                end else begin
                  x_out_r <= x_out_r;
                end
                if (in_bounds_s) begin
                  W_EN   <= 1'b1;
                  W_ADDR <= row_base_r + x_out_r[ADDR_W-1:0];
                  W_DATA <= pixel_s;
                end else begin
                  OVERFLOW <= 1'b1;
                end
              end else begin
                line_kept_r <= line_kept_r;
              end
            end
          end else begin
            phase_r <= phase_r;
          end
          if (VSYNC) begin
            state_r    <= VBLANK;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b1;
          end else begin
            state_r <= ACTIVE;
            BUSY    <= 1'b1;
          end
        end
        default: begin
          state_r <= WAIT_VS;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule
